fifo_rd_ctrl: RTL and testbench



---
 rtl/fifo_pkg.sv | 25 ++
 rtl/sync_w2r.sv | 30 +++
 rtl/fifo_rd_ctrl.sv | 82 ++++++++
 tb/tb_fifo_rd_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared dual-clock FIFO definitions: default geometry and Gray/binary conversion,
// used by both the read-side and write-side pointer controllers.
package fifo_pkg;

    localparam int unsigned DEF_ASIZE       = 4;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    // Conversions operate on a fixed 32-bit container; callers zero-extend their
    // pointer into it and truncate the result, which is exact for any width <= 32.
    localparam int unsigned FUNC_W = 32;

    function automatic logic [FUNC_W-1:0] bin2gray(input logic [FUNC_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [FUNC_W-1:0] gray2bin(input logic [FUNC_W-1:0] g);
        logic [FUNC_W-1:0] b;
        b[FUNC_W-1] = g[FUNC_W-1];
        for (int i = FUNC_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_w2r.sv
// N-stage synchronizer carrying the write-domain Gray pointer into the read clock.
// Pure flop chain: every bit sees the same number of stages, no logic in between.
module sync_w2r #(
    parameter int unsigned W      = 5,
    parameter int unsigned STAGES = 2
) (
    input  logic         rclk,
    input  logic         rrst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [STAGES];

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain pointer/empty controller for the dual-clock FIFO.
// Optional registered occupancy output rlevel is enabled with FIFO_RD_LEVEL_EN.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ASIZE       = DEF_ASIZE,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [ASIZE:0]   wptr,
    input  logic             rinc,
    output logic [ASIZE-1:0] raddr,
    output logic [ASIZE:0]   rptr,
    output logic             rempty,
    output logic             rerr
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [ASIZE:0]   rlevel
`endif
);

    localparam int unsigned PW = ASIZE + 1;

    logic [PW-1:0] rq_wptr;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic          pop;

    sync_w2r #(
        .W      (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync_w2r (
        .rclk (rclk),
        .rrst (rrst),
        .d    (wptr),
        .q    (rq_wptr)
    );

    // Popping an empty FIFO is blocked here and flagged as underflow below.
    always_comb begin
        pop        = rinc & ~rempty;
        rbin_next  = rbin + PW'(pop);
        rgray_next = PW'(bin2gray(FUNC_W'(rbin_next)));
    end

    // Empty compares the full pointer width, so the wrap bit keeps full from aliasing empty.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin   <= '0;
            rptr   <= '0;
            raddr  <= '0;
            rempty <= 1'b1;
            rerr   <= 1'b0;
        end else begin
            rbin   <= rbin_next;
            rptr   <= rgray_next;
            raddr  <= rbin_next[ASIZE-1:0];
            rempty <= (rgray_next == rq_wptr);
            rerr   <= rerr | (rinc & rempty);
        end
    end

`ifdef FIFO_RD_LEVEL_EN
    logic [PW-1:0] rq_wbin;

    always_comb begin
        rq_wbin = PW'(gray2bin(FUNC_W'(rq_wptr)));
    end

    // Uses the synchronized write pointer, so the count lags writes and never overstates.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rlevel <= '0;
        end else begin
            rlevel <= rq_wbin - rbin_next;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed scoreboard bench for fifo_rd_ctrl (ASIZE=4, SYNC_STAGES=2).
// Covers rlevel as well when built with FIFO_RD_LEVEL_EN.
module tb_fifo_rd_ctrl;

    logic       rclk;
    logic       rrst;
    logic [4:0] wptr;
    logic       rinc;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic       rerr;
`ifdef FIFO_RD_LEVEL_EN
    logic [4:0] rlevel;
`endif
    logic       clk_en;

    int ntests = 0;
    int nfail  = 0;

    typedef struct {
        string      tag;
        logic [3:0] raddr;
        logic [4:0] rptr;
        logic       rempty;
        logic       rerr;
    } exp_t;

    exp_t sb[$];

    fifo_rd_ctrl #(
        .ASIZE       (4),
        .SYNC_STAGES (2)
    ) dut (
        .rclk   (rclk),
        .rrst   (rrst),
        .wptr   (wptr),
        .rinc   (rinc),
        .raddr  (raddr),
        .rptr   (rptr),
        .rempty (rempty),
        .rerr   (rerr)
`ifdef FIFO_RD_LEVEL_EN
        ,
        .rlevel (rlevel)
`endif
    );

    always begin
        #5;
        if (clk_en) rclk = ~rclk;
    end

    function automatic logic [4:0] g5(input int b);
        logic [4:0] x;
        x = 5'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int a, input logic [4:0] g,
                        input logic e, input logic r);
        exp_t x;
        x.tag = tag; x.raddr = 4'(a); x.rptr = g; x.rempty = e; x.rerr = r;
        sb.push_back(x);
    endtask

    task automatic check_out();
        exp_t x;
        if (sb.size() == 0) begin
            cmp("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            x = sb.pop_front();
            cmp({x.tag, ".raddr"},  32'(raddr),  32'(x.raddr));
            cmp({x.tag, ".rptr"},   32'(rptr),   32'(x.rptr));
            cmp({x.tag, ".rempty"}, 32'(rempty), 32'(x.rempty));
            cmp({x.tag, ".rerr"},   32'(rerr),   32'(x.rerr));
        end
    endtask

    task automatic check_level(input string tag, input int exp);
`ifdef FIFO_RD_LEVEL_EN
        cmp({tag, ".rlevel"}, 32'(rlevel), 32'(exp));
`endif
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    initial begin
        rclk = 1'b0; clk_en = 1'b0;
        rrst = 1'b1; wptr = '0; rinc = 1'b0;

        // reset with clock stopped
        #3;
        push("reset", 0, 5'b00000, 1'b1, 1'b0);
        check_out();
        check_level("reset", 0);
        #2;
        rrst = 1'b0; clk_en = 1'b1;

        tick();
        push("idle", 0, 5'b00000, 1'b1, 1'b0);
        check_out();

        // single write: empty must clear exactly on the 3rd edge
        wptr = 5'b00001;
        for (int k = 1; k <= 3; k++) begin
            push($sformatf("single_wait%0d", k), 0, 5'b00000, (k < 3), 1'b0);
            tick();
            check_out();
        end
        rinc = 1'b1;
        push("single_pop", 1, 5'b00001, 1'b1, 1'b0);
        tick();
        check_out();
        rinc = 1'b0;

        // restart both sides
        rrst = 1'b1; wptr = '0;
        #1;
        push("rst2", 0, 5'b00000, 1'b1, 1'b0);
        check_out();
        rrst = 1'b0;

        // full FIFO then a complete pass with wrap
        wptr = 5'b11000;
        for (int k = 1; k <= 3; k++) begin
            push($sformatf("full_wait%0d", k), 0, 5'b00000, (k < 3), 1'b0);
            tick();
            check_out();
        end
        rinc = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            push($sformatf("wrap_pop%0d", k), k % 16, g5(k), (k == 16), 1'b0);
            tick();
            check_out();
        end

        // underflow: pointers frozen, sticky error
        for (int k = 1; k <= 3; k++) begin
            push($sformatf("underflow%0d", k), 0, 5'b11000, 1'b1, 1'b1);
            tick();
            check_out();
        end
        rinc = 1'b0;
        push("underflow_hold", 0, 5'b11000, 1'b1, 1'b1);
        tick();
        check_out();

        rrst = 1'b1; wptr = '0;
        #1;
        push("rst3", 0, 5'b00000, 1'b1, 1'b0);
        check_out();
        rrst = 1'b0;

        // ten entries, level tracking, then reset mid-operation
        wptr = g5(10);
        for (int k = 1; k <= 3; k++) begin
            push($sformatf("lvl_wait%0d", k), 0, 5'b00000, (k < 3), 1'b0);
            tick();
            check_out();
        end
        check_level("lvl_settled", 10);
        rinc = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            push($sformatf("lvl_pop%0d", k), k, g5(k), 1'b0, 1'b0);
            tick();
            check_out();
            check_level($sformatf("lvl_pop%0d", k), 10 - k);
        end
        rinc = 1'b0;
        push("lvl_idle", 3, g5(3), 1'b0, 1'b0);
        tick();
        check_out();
        check_level("lvl_idle", 7);
        rinc = 1'b1;
        for (int k = 4; k <= 5; k++) begin
            push($sformatf("mid_pop%0d", k), k, g5(k), 1'b0, 1'b0);
            tick();
            check_out();
        end
        rinc = 1'b0;
        #3;
        rrst = 1'b1;
        #1;
        push("mid_reset", 0, 5'b00000, 1'b1, 1'b0);
        check_out();
        check_level("mid_reset", 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
